// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register bank with a per-register busy scoreboard.
// Serves both the integer file (ZERO_REG=1, x0 hardwired to zero) and the
// FP file (ZERO_REG=0). Reads are combinational. Writes, busy bits and
// busy_count update on the rising clock edge.
// Optional feature: define REG_FILE_SB_BYPASS_EN to forward writeback data
// to the read ports in the same cycle.
module reg_file_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  parameter int ADDR_W   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic              read_reg_port1,
  input  logic              read_reg_port2,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              wb_signal,
  input  logic [ADDR_W-1:0] rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [ADDR_W:0]   busy_count
);

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic [ADDR_W:0]  count;
  logic [ADDR_W:0]  count_next;
  logic [ADDR_W:0]  n_set;
  logic [ADDR_W:0]  n_clr;
  logic             set_hit;
  logic             clr_hit;
  logic             rs1_zero;
  logic             rs2_zero;
  logic             rd_zero;

  // Register 0 is hardwired only in the integer-file configuration.
  assign rs1_zero = (ZERO_REG != 0) && (rs1 == {ADDR_W{1'b0}});
  assign rs2_zero = (ZERO_REG != 0) && (rs2 == {ADDR_W{1'b0}});
  assign rd_zero  = (ZERO_REG != 0) && (rd == {ADDR_W{1'b0}});

  // Register storage: clears on reset, takes writeback data on wb_signal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= {XLEN{1'b0}};
      end
    end else if (wb_signal && !rd_zero) begin
      regs[rd] <= wb_data;
    end
  end

  // Read port 1: gated data and busy, with optional same-cycle forwarding.
  always_comb begin
    rs1_data = {XLEN{1'b0}};
    rs1_busy = 1'b0;
    if (read_reg_port1 && !rs1_zero) begin
`ifdef REG_FILE_SB_BYPASS_EN
      if (wb_signal && (rd == rs1)) begin
        rs1_data = wb_data;
        rs1_busy = 1'b0;
      end else begin
        rs1_data = regs[rs1];
        rs1_busy = busy[rs1];
      end
`else
      rs1_data = regs[rs1];
      rs1_busy = busy[rs1];
`endif
    end else begin
      rs1_data = {XLEN{1'b0}};
      rs1_busy = 1'b0;
    end
  end

  // Read port 2: same behaviour as port 1.
  always_comb begin
    rs2_data = {XLEN{1'b0}};
    rs2_busy = 1'b0;
    if (read_reg_port2 && !rs2_zero) begin
`ifdef REG_FILE_SB_BYPASS_EN
      if (wb_signal && (rd == rs2)) begin
        rs2_data = wb_data;
        rs2_busy = 1'b0;
      end else begin
        rs2_data = regs[rs2];
        rs2_busy = busy[rs2];
      end
`else
      rs2_data = regs[rs2];
      rs2_busy = busy[rs2];
`endif
    end else begin
      rs2_data = {XLEN{1'b0}};
      rs2_busy = 1'b0;
    end
  end

  // Scoreboard next state; issue beats writeback on the same register, and
  // the count moves only on real 0->1 / 1->0 transitions so it cannot wrap.
  always_comb begin
    busy_next = busy;
    n_set     = {(ADDR_W + 1){1'b0}};
    n_clr     = {(ADDR_W + 1){1'b0}};
    set_hit   = 1'b0;
    clr_hit   = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      set_hit = issue_valid && (issue_rd == ADDR_W'(r)) && !((ZERO_REG != 0) && (r == 0));
      clr_hit = wb_signal && (rd == ADDR_W'(r));
      if (set_hit) begin
        busy_next[r] = 1'b1;
        if (!busy[r]) begin
          n_set = n_set + CNT_ONE;
        end else begin
          n_set = n_set;
        end
      end else if (clr_hit) begin
        busy_next[r] = 1'b0;
        if (busy[r]) begin
          n_clr = n_clr + CNT_ONE;
        end else begin
          n_clr = n_clr;
        end
      end else begin
        busy_next[r] = busy[r];
      end
    end
    count_next = count + n_set - n_clr;
  end

  // Scoreboard and busy-count state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= {NREGS{1'b0}};
      count <= {(ADDR_W + 1){1'b0}};
    end else begin
      busy  <= busy_next;
      count <= count_next;
    end
  end

  assign busy_count = count;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb. Two instances: "a" is the default integer
// file (32 x 32, ZERO_REG=1); "b" is an 8-entry file with ZERO_REG=0.
// Expectations for the forwarding cases follow REG_FILE_SB_BYPASS_EN.
module tb_reg_file_sb;

  logic clk;
  logic rst;

  // instance a
  logic [4:0]  a_rs1, a_rs2, a_issue_rd, a_rd;
  logic        a_en1, a_en2, a_issue_valid, a_wb;
  logic [31:0] a_wb_data, a_rs1_data, a_rs2_data;
  logic        a_rs1_busy, a_rs2_busy;
  logic [5:0]  a_count;

  // instance b
  logic [2:0]  b_rs1, b_rs2, b_issue_rd, b_rd;
  logic        b_en1, b_en2, b_issue_valid, b_wb;
  logic [31:0] b_wb_data, b_rs1_data, b_rs2_data;
  logic        b_rs1_busy, b_rs2_busy;
  logic [3:0]  b_count;

  int n_cmp;
  int n_bad;

  reg_file_sb dut_a (
    .clk(clk), .rst(rst),
    .rs1(a_rs1), .rs2(a_rs2),
    .read_reg_port1(a_en1), .read_reg_port2(a_en2),
    .rs1_data(a_rs1_data), .rs2_data(a_rs2_data),
    .rs1_busy(a_rs1_busy), .rs2_busy(a_rs2_busy),
    .issue_valid(a_issue_valid), .issue_rd(a_issue_rd),
    .wb_signal(a_wb), .rd(a_rd), .wb_data(a_wb_data),
    .busy_count(a_count)
  );

  reg_file_sb #(.XLEN(32), .NREGS(8), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst),
    .rs1(b_rs1), .rs2(b_rs2),
    .read_reg_port1(b_en1), .read_reg_port2(b_en2),
    .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
    .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
    .issue_valid(b_issue_valid), .issue_rd(b_issue_rd),
    .wb_signal(b_wb), .rd(b_rd), .wb_data(b_wb_data),
    .busy_count(b_count)
  );

  // free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1 unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    a_rs1 = 5'd5; a_rs2 = 5'd31; a_en1 = 1'b1; a_en2 = 1'b1;
    a_issue_valid = 1'b0; a_issue_rd = 5'd0; a_wb = 1'b0; a_rd = 5'd0; a_wb_data = 32'd0;
    b_rs1 = 3'd0; b_rs2 = 3'd0; b_en1 = 1'b0; b_en2 = 1'b0;
    b_issue_valid = 1'b0; b_issue_rd = 3'd0; b_wb = 1'b0; b_rd = 3'd0; b_wb_data = 32'd0;
    #2;
    // reset state
    check("rst_rs1_data", 64'(a_rs1_data), 64'h0);
    check("rst_rs2_data", 64'(a_rs2_data), 64'h0);
    check("rst_count_a", 64'(a_count), 64'd0);
    check("rst_count_b", 64'(b_count), 64'd0);
    check("rst_rs1_busy", 64'(a_rs1_busy), 64'd0);
    a_en1 = 1'b0; a_en2 = 1'b0;
    #1;
    check("rst_dis_rs1_data", 64'(a_rs1_data), 64'h0);
    check("rst_dis_rs2_data", 64'(a_rs2_data), 64'h0);
    tick();
    rst = 1'b0;

    // write r7, same-cycle read shows old value unless forwarded
    a_wb = 1'b1; a_rd = 5'd7; a_wb_data = 32'hDEADBEEF;
    a_rs1 = 5'd7; a_en1 = 1'b1;
    #1;
`ifdef REG_FILE_SB_BYPASS_EN
    check("same_cycle_r7", 64'(a_rs1_data), 64'hDEADBEEF);
`else
    check("same_cycle_r7", 64'(a_rs1_data), 64'h0);
`endif
    tick();
    a_wb = 1'b0;
    #1;
    check("read_r7", 64'(a_rs1_data), 64'hDEADBEEF);
    a_en1 = 1'b0;
    #1;
    check("read_r7_disabled", 64'(a_rs1_data), 64'h0);

    // register 0: hardwired in a, ordinary in b
    a_wb = 1'b1; a_rd = 5'd0; a_wb_data = 32'h1234;
    b_wb = 1'b1; b_rd = 3'd0; b_wb_data = 32'h1234;
    tick();
    a_wb = 1'b0; b_wb = 1'b0;
    a_rs1 = 5'd0; a_en1 = 1'b1;
    b_rs1 = 3'd0; b_en1 = 1'b1;
    #1;
    check("x0_read_a", 64'(a_rs1_data), 64'h0);
    check("f0_read_b", 64'(b_rs1_data), 64'h1234);

    // scoreboard: issue r3, r9
    a_issue_valid = 1'b1; a_issue_rd = 5'd3;
    tick();
    a_issue_rd = 5'd9;
    tick();
    a_issue_valid = 1'b0;
    a_rs1 = 5'd3; a_en1 = 1'b1;
    #1;
    check("count_after_2_issue", 64'(a_count), 64'd2);
    check("rs1_busy_r3", 64'(a_rs1_busy), 64'd1);
    a_en1 = 1'b0;
    #1;
    check("rs1_busy_r3_disabled", 64'(a_rs1_busy), 64'd0);
    a_en1 = 1'b1;
    a_wb = 1'b1; a_rd = 5'd3; a_wb_data = 32'h33;
    tick();
    a_wb = 1'b0;
    #1;
    check("count_after_wb_r3", 64'(a_count), 64'd1);
    check("rs1_busy_r3_cleared", 64'(a_rs1_busy), 64'd0);
    check("rs1_data_r3", 64'(a_rs1_data), 64'h33);

    // x0 never becomes busy
    a_issue_valid = 1'b1; a_issue_rd = 5'd0;
    tick();
    a_issue_valid = 1'b0;
    a_rs1 = 5'd0;
    #1;
    check("x0_issue_count", 64'(a_count), 64'd1);
    check("x0_busy", 64'(a_rs1_busy), 64'd0);

    // simultaneous issue and writeback of r4
    a_issue_valid = 1'b1; a_issue_rd = 5'd4;
    tick();
    check("count_issue_r4", 64'(a_count), 64'd2);
    a_wb = 1'b1; a_rd = 5'd4; a_wb_data = 32'h44;
    tick();
    a_issue_valid = 1'b0; a_wb = 1'b0;
    a_rs2 = 5'd4; a_en2 = 1'b1;
    #1;
    check("count_issue_wb_r4", 64'(a_count), 64'd2);
    check("rs2_busy_r4", 64'(a_rs2_busy), 64'd1);

    // b: fill all 8, re-issue, clear all, stray clear
    b_issue_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b_issue_rd = 3'(i);
      tick();
    end
    check("b_full_count", 64'(b_count), 64'd8);
    b_issue_rd = 3'd2;
    tick();
    b_issue_valid = 1'b0;
    check("b_reissue_count", 64'(b_count), 64'd8);
    b_wb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b_rd = 3'(i); b_wb_data = 32'(i + 100);
      tick();
    end
    check("b_cleared_count", 64'(b_count), 64'd0);
    b_rd = 3'd5; b_wb_data = 32'h55;
    tick();
    b_wb = 1'b0;
    b_rs2 = 3'd5; b_en2 = 1'b1;
    #1;
    check("b_stray_wb_count", 64'(b_count), 64'd0);
    check("b_r5_data", 64'(b_rs2_data), 64'h55);

    // forwarding on r10 while busy
    a_wb = 1'b1; a_rd = 5'd10; a_wb_data = 32'h01020304;
    tick();
    a_wb = 1'b0;
    a_issue_valid = 1'b1; a_issue_rd = 5'd10;
    tick();
    a_issue_valid = 1'b0;
    check("count_issue_r10", 64'(a_count), 64'd3);
    a_wb = 1'b1; a_rd = 5'd10; a_wb_data = 32'hA5A5A5A5;
    a_rs2 = 5'd10; a_en2 = 1'b1;
    #1;
`ifdef REG_FILE_SB_BYPASS_EN
    check("bypass_rs2_data", 64'(a_rs2_data), 64'hA5A5A5A5);
    check("bypass_rs2_busy", 64'(a_rs2_busy), 64'd0);
`else
    check("nobypass_rs2_data", 64'(a_rs2_data), 64'h01020304);
    check("nobypass_rs2_busy", 64'(a_rs2_busy), 64'd1);
`endif
    tick();
    a_wb = 1'b0;
    #1;
    check("r10_after_wb", 64'(a_rs2_data), 64'hA5A5A5A5);
    check("r10_busy_after_wb", 64'(a_rs2_busy), 64'd0);
    check("count_after_wb_r10", 64'(a_count), 64'd2);

    // asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_count", 64'(a_count), 64'd0);
    a_rs1 = 5'd7; a_en1 = 1'b1;
    #1;
    check("async_rst_r7", 64'(a_rs1_data), 64'h0);
    rst = 1'b0;

    // late writeback of pre-reset issue r9: data lands, clear is a no-op
    a_wb = 1'b1; a_rd = 5'd9; a_wb_data = 32'h99;
    a_rs1 = 5'd9;
    tick();
    a_wb = 1'b0;
    #1;
    check("late_wb_count", 64'(a_count), 64'd0);
    check("late_wb_data", 64'(a_rs1_data), 64'h99);
    check("late_wb_busy", 64'(a_rs1_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
